// File: rtl/hack_io_pkg.sv
// Shared constants for the Hack memory-mapped I/O block: register addresses
// and the default bit layout of the switch/button read word.
package hack_io_pkg;

    localparam int unsigned IO_DATA_W = 16;

    localparam logic [15:0] KBD_ADDR = 16'h6000;
    localparam logic [15:0] LED_ADDR = 16'h6001;
    localparam logic [15:0] SW_ADDR  = 16'h6002;

    // Default layout: 10 switches, 2 buttons, 2 press flags.
    localparam int unsigned SW_LSB  = 0;
    localparam int unsigned BTN_LSB = 10;
    localparam int unsigned PF_LSB  = 12;

endpackage

// File: rtl/debouncer.sv
// One-bit two-flop synchroniser followed by a counting debouncer. Works in the
// raw pad polarity; RESET_LEVEL is the pad's idle level.
module debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count only while the synced level disagrees; any agreement restarts it.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            stable_q <= RESET_LEVEL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/switch_input.sv
// Memory-mapped read register for slide switches and push-buttons: debounced
// levels plus sticky press flags cleared by a CPU read.
module switch_input
    import hack_io_pkg::*;
#(
    parameter int unsigned N_SW            = 10,
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SW-1:0]      sw,
    input  logic [N_BTN-1:0]     btn,
    input  logic                 read,
    output logic [IO_DATA_W-1:0] out
);

    logic [N_SW-1:0]  sw_stable;
    logic [N_BTN-1:0] btn_pad_stable;
    logic [N_BTN-1:0] btn_stable;
    logic [N_BTN-1:0] btn_prev_q, btn_prev_d;
    logic [N_BTN-1:0] pf_q, pf_d;
    logic [N_BTN-1:0] press_rise;
    logic [N_BTN-1:0] pf_vis;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (1'b0)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (sw[i]),
            .stable (sw_stable[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (BTN_ACTIVE_LOW)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (btn[i]),
            .stable (btn_pad_stable[i])
        );
    end

    assign btn_stable = BTN_ACTIVE_LOW ? ~btn_pad_stable : btn_pad_stable;

    // A press is visible on the edge its stable bit rises, via press_rise, and
    // is folded into pf_q on the following edge unless that edge is a read.
    always_comb begin
        press_rise = btn_stable & ~btn_prev_q;
        pf_vis     = pf_q | press_rise;
        pf_d       = read ? '0 : pf_vis;
        btn_prev_d = btn_stable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= '0;
            pf_q       <= '0;
        end else begin
            btn_prev_q <= btn_prev_d;
            pf_q       <= pf_d;
        end
    end

    always_comb begin
        out                          = '0;
        out[N_SW-1:0]                = sw_stable;
        out[N_SW +: N_BTN]           = btn_stable;
        out[N_SW + N_BTN +: N_BTN]   = pf_vis;
    end

endmodule
